// File: rtl/perceptron_trainer_fixed.sv
// Sequential perceptron trainer, Q3.12 fixed point: runs the perceptron learning
// rule over a 4-sample truth table until an error-free epoch or the epoch limit.
module perceptron_trainer_fixed #(
  parameter int tam        = 16,
  parameter int frac       = 12,
  parameter int max_epochs = 64,
  parameter int eta_shift  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0][tam-1:0] in1,
  input  logic [3:0][tam-1:0] in2,
  input  logic [3:0][tam-1:0] d,
  input  logic [tam-1:0]      w0_init,
  input  logic [tam-1:0]      w1_init,
  input  logic [tam-1:0]      w2_init,
  output logic [tam-1:0]      w0,
  output logic [tam-1:0]      w1,
  output logic [tam-1:0]      w2,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic [7:0]          epochs
);

  localparam int NW = 2*tam + 2;
  localparam logic [tam-1:0] ETA = {{(tam-1){1'b0}}, 1'b1} << (frac - eta_shift);

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE, DONE} state_t;

  state_t               state_q;
  logic [3:0][tam-1:0]  x1_q, x2_q;
  logic [3:0]           dbit_q;
  logic [tam-1:0]       w0_q, w1_q, w2_q;
  logic [tam-1:0]       w0_d, w1_d, w2_d;
  logic [1:0]           idx_q;
  logic [7:0]           epoch_q;
  logic [2:0]           errcnt_q, errcnt_d;
  logic                 errp_q, errn_q;
  logic                 busy_q, done_q, conv_q;

  logic [tam-1:0]          xa, xb;
  logic signed [2*tam-1:0] ea, eb, ew1, ew2, p1, p2, s1, s2;
  logic signed [NW-1:0]    net;
  logic                    y, err_any;
  logic signed [tam-1:0]   dx1, dx2;

  function automatic logic [tam-1:0] sat_add(input logic [tam-1:0] a,
                                             input logic [tam-1:0] b,
                                             input logic           sub);
    logic [tam:0] s;
    s = sub ? ({a[tam-1], a} - {b[tam-1], b}) : ({a[tam-1], a} + {b[tam-1], b});
    if (s[tam] != s[tam-1])
      return s[tam] ? {1'b1, {(tam-1){1'b0}}} : {1'b0, {(tam-1){1'b1}}};
    return s[tam-1:0];
  endfunction

  // Products are formed at 2*tam and the sum at 2*tam+2 so net can never wrap.
  always_comb begin
    xa  = x1_q[idx_q];
    xb  = x2_q[idx_q];
    ea  = {{tam{xa[tam-1]}}, xa};
    eb  = {{tam{xb[tam-1]}}, xb};
    ew1 = {{tam{w1_q[tam-1]}}, w1_q};
    ew2 = {{tam{w2_q[tam-1]}}, w2_q};
    p1  = ew1 * ea;
    p2  = ew2 * eb;
    s1  = p1 >>> frac;
    s2  = p2 >>> frac;
    net = {{(NW-tam){w0_q[tam-1]}}, w0_q}
        + {{2{s1[2*tam-1]}}, s1}
        + {{2{s2[2*tam-1]}}, s2};
    y   = ~net[NW-1] && (net != '0);

    dx1      = $signed(xa) >>> eta_shift;
    dx2      = $signed(xb) >>> eta_shift;
    w0_d     = sat_add(w0_q, ETA, errn_q);
    w1_d     = sat_add(w1_q, dx1, errn_q);
    w2_d     = sat_add(w2_q, dx2, errn_q);
    err_any  = errp_q | errn_q;
    errcnt_d = errcnt_q + {2'b00, err_any};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x1_q     <= '0;
      x2_q     <= '0;
      dbit_q   <= '0;
      w0_q     <= '0;
      w1_q     <= '0;
      w2_q     <= '0;
      idx_q    <= '0;
      epoch_q  <= '0;
      errcnt_q <= '0;
      errp_q   <= 1'b0;
      errn_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      conv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            x1_q <= in1;
            x2_q <= in2;
            for (int unsigned i = 0; i < 4; i++) dbit_q[i] <= (d[i] != '0);
            w0_q     <= w0_init;
            w1_q     <= w1_init;
            w2_q     <= w2_init;
            idx_q    <= '0;
            epoch_q  <= '0;
            errcnt_q <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            conv_q   <= 1'b0;
            state_q  <= EVAL;
          end
        end
        EVAL: begin
          errp_q  <= dbit_q[idx_q] & ~y;
          errn_q  <= ~dbit_q[idx_q] & y;
          state_q <= UPDATE;
        end
        UPDATE: begin
          if (err_any) begin
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            errcnt_q <= errcnt_d;
          end
          if (idx_q != 2'd3) begin
            idx_q   <= idx_q + 2'd1;
            state_q <= EVAL;
          end else begin
            epoch_q <= epoch_q + 8'd1;
            if (errcnt_d == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              conv_q  <= 1'b1;
              state_q <= DONE;
            end else if (epoch_q + 8'd1 == 8'(max_epochs)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              conv_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              idx_q    <= '0;
              errcnt_q <= '0;
              state_q  <= EVAL;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w0        = w0_q;
  assign w1        = w1_q;
  assign w2        = w2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = conv_q;
  assign epochs    = epoch_q;

endmodule

// File: tb/tb_perceptron_trainer_fixed.sv
// Directed bench for perceptron_trainer_fixed: OR/XOR/AND training, saturation,
// start-while-busy, mid-run reset and retrain from DONE.
module tb_perceptron_trainer_fixed;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [3:0][15:0] in1, in2, d;
  logic [15:0]      w0_init, w1_init, w2_init;
  logic [15:0]      w0, w1, w2;
  logic             busy, done, converged;
  logic [7:0]       epochs;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  perceptron_trainer_fixed #(.tam(16), .frac(12), .max_epochs(8), .eta_shift(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in1(in1), .in2(in2), .d(d),
    .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init),
    .w0(w0), .w1(w1), .w2(w2),
    .busy(busy), .done(done), .converged(converged), .epochs(epochs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts further busy cycles into n, bounded.
  task automatic wait_idle();
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk("timeout", 32'(n < 2000), 32'd1);
  endtask

  // Independent model of the downstream gate stage: net > 0.
  function automatic logic gate(input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] a2, input logic [15:0] x1,
                                input logic [15:0] x2);
    longint b0, b1, b2, v1, v2, s;
    b0 = longint'($signed(a0));
    b1 = longint'($signed(a1));
    b2 = longint'($signed(a2));
    v1 = longint'($signed(x1));
    v2 = longint'($signed(x2));
    s  = b0 + ((b1 * v1) >>> 12) + ((b2 * v2) >>> 12);
    return s > 0;
  endfunction

  task automatic set_or();
    in1 = {16'h1000, 16'h0000, 16'h1000, 16'h0000};
    in2 = {16'h1000, 16'h1000, 16'h0000, 16'h0000};
    d   = {16'h0001, 16'h0001, 16'h0001, 16'h0000};
    w0_init = 16'h0000; w1_init = 16'h0000; w2_init = 16'h0000;
  endtask

  task automatic check_or(input string p);
    chk({p, "_cycles"}, 32'(n), 32'd32);
    chk({p, "_done"}, {31'd0, done}, 32'd1);
    chk({p, "_conv"}, {31'd0, converged}, 32'd1);
    chk({p, "_epochs"}, {24'd0, epochs}, 32'd4);
    chk({p, "_w0"}, {16'd0, w0}, 32'h0000);
    chk({p, "_w1"}, {16'd0, w1}, 32'h0800);
    chk({p, "_w2"}, {16'd0, w2}, 32'h0800);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    set_or();
    tick(); tick();
    rst = 1'b0;
    chk("rst_w0", {16'd0, w0}, 32'd0);
    chk("rst_w1", {16'd0, w1}, 32'd0);
    chk("rst_w2", {16'd0, w2}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_conv", {31'd0, converged}, 32'd0);
    chk("rst_epochs", {24'd0, epochs}, 32'd0);

    // OR
    pulse_start();
    chk("or_busy_rise", {31'd0, busy}, 32'd1);
    n = 0;
    wait_idle();
    check_or("or");

    // XOR: not separable, stops at the epoch limit
    d = {16'h0000, 16'h0001, 16'h0001, 16'h0000};
    pulse_start();
    n = 0;
    wait_idle();
    chk("xor_cycles", 32'(n), 32'd64);
    chk("xor_done", {31'd0, done}, 32'd1);
    chk("xor_conv", {31'd0, converged}, 32'd0);
    chk("xor_epochs", {24'd0, epochs}, 32'd8);

    // Saturation
    in1 = {4{16'h1000}};
    in2 = {4{16'h0000}};
    d   = {4{16'h0001}};
    w0_init = 16'h7F00; w1_init = 16'h8000; w2_init = 16'h0000;
    pulse_start();
    chk("sat_load_w0", {16'd0, w0}, 32'h7F00);
    n = 0;
    tick(); n++;
    tick(); n++;
    chk("sat_w0", {16'd0, w0}, 32'h7FFF);
    chk("sat_w1", {16'd0, w1}, 32'h8800);
    chk("sat_w2", {16'd0, w2}, 32'h0000);
    wait_idle();
    chk("sat_cycles", 32'(n), 32'd16);
    chk("sat_conv", {31'd0, converged}, 32'd1);
    chk("sat_epochs", {24'd0, epochs}, 32'd2);

    // start while busy and mid-run input changes are ignored
    set_or();
    pulse_start();
    n = 0;
    tick(); n++;
    tick(); n++;
    in1[1] = 16'h0000;
    d[1]   = 16'h0000;
    d[0]   = 16'h0001;
    start  = 1'b1;
    tick(); n++;
    start  = 1'b0;
    tick(); n++;
    wait_idle();
    check_or("ign");

    // Reset during epoch 2
    set_or();
    pulse_start();
    for (int k = 0; k < 10; k++) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_w0", {16'd0, w0}, 32'd0);
    chk("mrst_w1", {16'd0, w1}, 32'd0);
    chk("mrst_w2", {16'd0, w2}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_conv", {31'd0, converged}, 32'd0);
    chk("mrst_epochs", {24'd0, epochs}, 32'd0);
    tick();
    chk("mrst_idle_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    n = 0;
    wait_idle();
    check_or("rerun");

    // Retrain from DONE with AND targets
    w0_init = 16'h0800; w1_init = 16'h0000; w2_init = 16'h0000;
    d = {16'h0001, 16'h0000, 16'h0000, 16'h0000};
    pulse_start();
    chk("and_done_drop", {31'd0, done}, 32'd0);
    chk("and_busy", {31'd0, busy}, 32'd1);
    n = 0;
    wait_idle();
    chk("and_cycles", 32'(n), 32'd48);
    chk("and_conv", {31'd0, converged}, 32'd1);
    chk("and_epochs", {24'd0, epochs}, 32'd6);
    chk("and_w0", {16'd0, w0}, 32'hF000);
    chk("and_w1", {16'd0, w1}, 32'h0800);
    chk("and_w2", {16'd0, w2}, 32'h1000);
    chk("and_g0", {31'd0, gate(w0, w1, w2, 16'h0000, 16'h0000)}, 32'd0);
    chk("and_g1", {31'd0, gate(w0, w1, w2, 16'h1000, 16'h0000)}, 32'd0);
    chk("and_g2", {31'd0, gate(w0, w1, w2, 16'h0000, 16'h1000)}, 32'd0);
    chk("and_g3", {31'd0, gate(w0, w1, w2, 16'h1000, 16'h1000)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
